pwm8_ule: RTL and testbench
===========================

// Module: pwm8_ule
// PURPOSE
//  8-bit PWM generator; the stage directly downstream of ule8.
//  - Free-running period counter is compared each cycle against an active duty
//    value through ule8; the compare result drives O.
//  - Duty/period updates arrive over a VALID/READY port into a shadow register.
//  - Shadow values take effect only at period wrap, so no runt or glitched pulses.
//  - Feeds LED/servo drivers on ice40 boards.
// PARAMETERS
//  WIDTH   8   counter/duty/top width; only 8 supported (matches ule8).
// PORTS
//  CLK          in   1  clock, rising edge
//  ASYNCRESETN  in   1  asynchronous, active-low reset
//  CE           in   1  count enable; gates counter, O update, wrap
//  VALID        in   1  update request; DUTY/TOP valid when high
//  READY        out  1  high when the shadow register is free
//  DUTY         in   8  requested high time, in counts
//  TOP          in   8  requested terminal count; period = TOP+1 CE cycles
//  O            out  1  PWM output, registered
//  WRAP         out  1  combinational; high on the last count of a period
// BEHAVIOUR
//  Reset (async assert, sync-to-CLK release):
//  - CNT=0, DUTY_A=0, TOP_A=0, shadow=0, PEND=0.
//  - Outputs: O=0, READY=1, WRAP=CE (because CNT==TOP_A==0).
//  Handshake:
//  - READY = ~PEND.
//  - VALID&READY at an edge captures DUTY/TOP into the shadow and sets PEND=1.
//  - VALID while READY=0 is ignored; the sender holds until READY.
//  - Capture is independent of CE.
//  Counter:
//  - WRAP = CE & (CNT==TOP_A).
//  - On CE: if WRAP, CNT<=0; else CNT<=CNT+1.
//  - CE=0 holds CNT and O.
//  Apply at wrap:
//  - If WRAP & PEND: DUTY_A<=shadow.DUTY, TOP_A<=shadow.TOP, PEND<=0.
//  - READY rises the following cycle.
//  - A capture in the same cycle as a WRAP with PEND=0 is not applied by that
//    wrap; it is applied at the next wrap.
//    - From reset state (TOP_A=0) that is the next CE cycle.
//  Compare:
//  - LT = ~ule8(DUTY_A, CNT), i.e. CNT<DUTY_A unsigned.
//  - On CE: O<=LT. Latency 1 cycle from CNT to O.
//  - Per period, O is high for min(DUTY_A, TOP_A+1) CE cycles.
//  Boundaries:
//  - DUTY_A=0 -> O constantly 0.
//  - DUTY_A>TOP_A -> O constantly 1.
//  - TOP_A=0 -> WRAP every CE cycle; O = (DUTY_A!=0).
//  - TOP_A=255 -> CNT wraps 255->0, no overflow path.
//  - ASYNCRESETN low mid-period: immediate return to reset state.
//    - The pending shadow is discarded.
// STRUCTURE
//  Shared package pwm_pkg:
//  - PWM_W=8.
//  - typedef pwm_cfg_t {duty[7:0], top[7:0]}, used for shadow and active regs.
//  Sub-module: instantiate existing ule8 (I0=DUTY_A, I1=CNT) for the compare.
//  - The compare is not reimplemented inline.
//  - The counter increment and CNT==TOP_A compare stay in this module.
// TESTING
//  1. Reset, VALID=1 DUTY=3 TOP=7, CE=1 continuous.
//     -> config active next CE cycle; O repeats 3 high / 5 low.
//     -> WRAP every 8th cycle.
//  2. DUTY=0 TOP=4 -> O stays 0; DUTY=9 TOP=4 -> O stays 1.
//     -> WRAP period 5 in both cases.
//  3. Mid-period (CNT=2, TOP_A=7) load DUTY=6 TOP=9.
//     -> READY=0 until the cycle after CNT=7 wrap.
//     -> current period completes with the old 3/5 pattern.
//     -> new period is 6 high / 4 low.
//  4. Second VALID while READY=0 (DUTY=1 TOP=1).
//     -> ignored; active config after next wrap is the first load.
//  5. CE toggled 1,0,0,1 during a period -> CNT/O/WRAP frozen while CE=0.
//     -> high-time counted in CE cycles only.
//  6. Drop ASYNCRESETN with no clock edge at CNT=5, PEND=1.
//     -> O=0, READY=1 immediately.
//     -> after release, DUTY_A=TOP_A=0 and O stays 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the pwm8_ule PWM generator.
//   PWM_W     : counter / duty / top width (8 only; matches ule8)
//   pwm_cfg_t : {duty, top} pair used for both the shadow and active registers
package pwm_pkg;

  localparam int unsigned PWM_W = 8;

  typedef struct packed {
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] top;
  } pwm_cfg_t;

endpackage

// File: rtl/ule8.sv
// Unsigned 8-bit less-or-equal comparator.
//   I0 : in  8  left operand
//   I1 : in  8  right operand
//   O  : out 1  1 when I0 <= I1 (unsigned)
module ule8 (
  input  logic [7:0] I0,
  input  logic [7:0] I1,
  output logic       O
);

  assign O = (I0 <= I1);

endmodule

// File: rtl/pwm8_ule.sv
// 8-bit PWM generator built on the ule8 comparator.
// A free-running period counter is compared against the active duty value;
// the registered compare result drives O. Duty/top updates enter a shadow
// register over a VALID/READY handshake and are applied only at period wrap,
// so no runt or glitched pulses are produced.
//   CLK         : in  1  clock, rising edge
//   ASYNCRESETN : in  1  asynchronous active-low reset
//   CE          : in  1  count enable; gates counter, O update and wrap
//   VALID       : in  1  update request; DUTY/TOP valid when high
//   READY       : out 1  shadow register free
//   DUTY        : in  8  requested high time in counts
//   TOP         : in  8  requested terminal count; period = TOP+1 CE cycles
//   O           : out 1  PWM output, registered
//   WRAP        : out 1  combinational; last count of the period (qualified by CE)
module pwm8_ule
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_W
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             CE,
  input  logic             VALID,
  output logic             READY,
  input  logic [WIDTH-1:0] DUTY,
  input  logic [WIDTH-1:0] TOP,
  output logic             O,
  output logic             WRAP
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  pwm_cfg_t         act_q, act_d;
  pwm_cfg_t         shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             o_q, o_d;

  logic duty_le_cnt;
  logic lt;
  logic capture;

  // O is high while CNT < DUTY_A, i.e. NOT (DUTY_A <= CNT).
  ule8 u_ule8 (
    .I0 (act_q.duty),
    .I1 (cnt_q),
    .O  (duty_le_cnt)
  );

  assign lt      = ~duty_le_cnt;
  assign WRAP    = CE & (cnt_q == act_q.top);
  assign READY   = ~pend_q;
  assign capture = VALID & ~pend_q;
  assign O       = o_q;

  always_comb begin
    cnt_d    = cnt_q;
    act_d    = act_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    o_d      = o_q;

    if (CE) begin
      cnt_d = WRAP ? '0 : cnt_q + PWM_W'(1);
      o_d   = lt;
    end

    // Apply uses the pending flag as it stood before this edge, so a capture
    // landing on the same wrap waits for the following wrap.
    if (WRAP && pend_q) begin
      act_d  = shadow_q;
      pend_d = 1'b0;
    end

    // Capture only happens with pend_q low, so it never collides with apply.
    if (capture) begin
      shadow_d.duty = DUTY;
      shadow_d.top  = TOP;
      pend_d        = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      cnt_q    <= '0;
      act_q    <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      o_q      <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      o_q      <= o_d;
    end
  end

endmodule

// File: tb/tb_pwm8_ule.sv
// Directed self-checking bench for pwm8_ule.
module tb_pwm8_ule;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       valid;
  logic       ready;
  logic [7:0] duty;
  logic [7:0] top;
  logic       o;
  logic       wrap;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_o;
  logic [15:0] exp_wrap;

  pwm8_ule dut (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .CE          (ce),
    .VALID       (valid),
    .READY       (ready),
    .DUTY        (duty),
    .TOP         (top),
    .O           (o),
    .WRAP        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    valid = 1'b0;
    duty  = 8'd0;
    top   = 8'd0;
    run(2);

    // Reset state
    chk("rst_o", o, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_wrap", wrap, 1'b1);

    // Test 1: load 3/7 straight out of reset
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1;
    duty  = 8'd3;
    top   = 8'd7;
    tick();
    chk("t1_cap_ready", ready, 1'b0);
    chk("t1_cap_o", o, 1'b0);
    chk("t1_cap_wrap", wrap, 1'b1);
    valid = 1'b0;
    tick();
    chk("t1_apply_ready", ready, 1'b1);
    chk("t1_apply_wrap", wrap, 1'b0);
    chk("t1_apply_o", o, 1'b0);
    exp_o    = 16'b0000_0111_0000_0111;
    exp_wrap = 16'b0100_0000_0100_0000;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t1_o", o, exp_o[k]);
      chk("t1_wrap", wrap, exp_wrap[k]);
    end

    // Test 3/4: mid-period load (CNT=2) then an ignored second request
    run(2);
    chk("t3_pre_o", o, 1'b1);
    valid = 1'b1;
    duty  = 8'd6;
    top   = 8'd9;
    tick();
    chk("t3_cap_ready", ready, 1'b0);
    chk("t3_cap_o", o, 1'b1);
    duty = 8'd1;
    top  = 8'd1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3_busy_ready", ready, 1'b0);
      chk("t3_old_o", o, 1'b0);
      chk("t3_old_wrap", wrap, (i == 4));
    end
    tick();
    chk("t3_ready_back", ready, 1'b1);
    chk("t3_new_wrap0", wrap, 1'b0);
    chk("t3_new_o0", o, 1'b0);
    valid    = 1'b0;
    exp_o    = 16'b0000_0100_0011_1111;
    exp_wrap = 16'b0000_0001_0000_0000;
    for (int k = 0; k < 11; k++) begin
      tick();
      chk("t3_o", o, exp_o[k]);
      chk("t3_wrap", wrap, exp_wrap[k]);
    end

    // Test 5: CE gating (active 6/9, CNT=1)
    run(4);
    chk("t5_cnt5_o", o, 1'b1);
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t5_hold_o", o, 1'b1);
      chk("t5_hold_wrap", wrap, 1'b0);
    end
    ce = 1'b1;
    tick();
    chk("t5_sixth_high", o, 1'b1);
    tick();
    chk("t5_fall", o, 1'b0);
    run(2);
    chk("t5_wrap_ce1", wrap, 1'b1);
    ce = 1'b0;
    #1;
    chk("t5_wrap_ce0", wrap, 1'b0);
    tick();
    chk("t5_wrap_held", wrap, 1'b0);
    chk("t5_o_held", o, 1'b0);
    ce = 1'b1;
    #1;
    chk("t5_wrap_resume", wrap, 1'b1);
    tick();
    chk("t5_after_wrap", wrap, 1'b0);
    tick();
    chk("t5_new_period_o", o, 1'b1);

    // Test 2: DUTY=0 TOP=4, then DUTY=9 TOP=4
    valid = 1'b1;
    duty  = 8'd0;
    top   = 8'd4;
    tick();
    valid = 1'b0;
    run(7);
    tick();
    chk("t2a_ready", ready, 1'b1);
    exp_wrap = 16'b0000_0001_0000_1000;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2a_o", o, 1'b0);
      chk("t2a_wrap", wrap, exp_wrap[k]);
    end
    valid = 1'b1;
    duty  = 8'd9;
    top   = 8'd4;
    tick();
    valid = 1'b0;
    run(3);
    tick();
    chk("t2b_last_old_o", o, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2b_o", o, 1'b1);
      chk("t2b_wrap", wrap, exp_wrap[k]);
    end

    // Test 6: async reset at CNT=5 with a pending update
    valid = 1'b1;
    duty  = 8'd6;
    top   = 8'd7;
    tick();
    valid = 1'b0;
    run(3);
    tick();
    valid = 1'b1;
    duty  = 8'd200;
    top   = 8'd255;
    tick();
    valid = 1'b0;
    run(4);
    chk("t6_pre_o", o, 1'b1);
    chk("t6_pre_ready", ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_o", o, 1'b0);
    chk("t6_rst_ready", ready, 1'b1);
    chk("t6_rst_wrap", wrap, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_post_o", o, 1'b0);
      chk("t6_post_wrap", wrap, 1'b1);
      chk("t6_post_ready", ready, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
